// File: rtl/dm_cache_ctrl_if.sv
// Bus bundle for the direct-mapped cache controller.
// It carries the CPU request/response, the tag and data memory ports, and the line memory port.
// The master modport is the controller's view; the slave modport is the environment's view.
interface dm_cache_ctrl_if #(
    parameter int TAG_W   = 18,
    parameter int INDEX_W = 10,
    parameter int LINE_W  = 128
);
    logic               cpu_valid;
    logic               cpu_rw;
    logic [31:0]        cpu_addr;
    logic [31:0]        cpu_wdata;
    logic               cpu_ready;
    logic [31:0]        cpu_rdata;

    logic [INDEX_W-1:0] tag_index;
    logic               tag_we;
    logic [TAG_W+1:0]   tag_wdata;
    logic [TAG_W+1:0]   tag_rdata;

    logic [INDEX_W-1:0] data_index;
    logic               data_we;
    logic [LINE_W-1:0]  data_wdata;
    logic [LINE_W-1:0]  data_rdata;

    logic               mem_valid;
    logic               mem_rw;
    logic [31:0]        mem_addr;
    logic [LINE_W-1:0]  mem_wdata;
    logic               mem_ready;
    logic [LINE_W-1:0]  mem_rdata;

    modport master (
        input  cpu_valid, cpu_rw, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata,
        output tag_index, tag_we, tag_wdata,
        input  tag_rdata,
        output data_index, data_we, data_wdata,
        input  data_rdata,
        output mem_valid, mem_rw, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        output cpu_valid, cpu_rw, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata,
        input  tag_index, tag_we, tag_wdata,
        output tag_rdata,
        input  data_index, data_we, data_wdata,
        output data_rdata,
        input  mem_valid, mem_rw, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Blocking controller for a direct-mapped, write-back, write-allocate cache.
// It handles one CPU load or store at a time.
// It performs the tag compare and, on a miss, writes back a dirty line before refilling the line.
// The tag and data memories read asynchronously and commit writes on the rising edge.
module dm_cache_ctrl #(
    parameter int TAG_W   = 18,
    parameter int INDEX_W = 10,
    parameter int LINE_W  = 128
) (
    input  logic            clk,
    input  logic            rst,
    dm_cache_ctrl_if.master bus
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] COMPARE    = 2'd1;
    localparam logic [1:0] WRITE_BACK = 2'd2;
    localparam logic [1:0] ALLOCATE   = 2'd3;

    logic [1:0]         state, state_nx;
    logic               req_rw;
    logic [31:2]        req_addr;
    logic [31:0]        req_wdata;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [1:0]         req_word;
    logic               ent_valid, ent_dirty;
    logic [TAG_W-1:0]   ent_tag;
    logic               hit;
    logic [LINE_W-1:0]  merged;
    logic [31:0]        hit_word;

    assign req_tag   = req_addr[31 -: TAG_W];
    assign req_index = req_addr[4 +: INDEX_W];
    assign req_word  = req_addr[3:2];

    assign {ent_valid, ent_dirty, ent_tag} = bus.tag_rdata;
    assign hit = (state == COMPARE) && ent_valid && (ent_tag == req_tag);

    // Select the addressed word for a load, and build the line with the store word merged in.
    always_comb begin
        hit_word = bus.data_rdata[{req_word, 5'b0} +: 32];
        merged   = bus.data_rdata;
        merged[{req_word, 5'b0} +: 32] = req_wdata;
    end

    // Next-state logic and all memory-side outputs. Nothing is registered, so reset drops mem_valid at once.
    always_comb begin
        state_nx       = state;
        bus.tag_index  = (state == IDLE) ? '0 : req_index;
        bus.data_index = (state == IDLE) ? '0 : req_index;
        bus.tag_we     = 1'b0;
        bus.tag_wdata  = {1'b1, 1'b1, req_tag};
        bus.data_we    = 1'b0;
        bus.data_wdata = merged;
        bus.mem_valid  = 1'b0;
        bus.mem_rw     = 1'b0;
        bus.mem_addr   = {req_tag, req_index, 4'b0};
        bus.mem_wdata  = bus.data_rdata;
        case (state)
            IDLE: begin
                if (bus.cpu_valid) state_nx = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    // A store hit writes in place and marks the line dirty.
                    bus.tag_we  = req_rw;
                    bus.data_we = req_rw;
                    state_nx    = IDLE;
                end else if (ent_valid && ent_dirty) begin
                    state_nx = WRITE_BACK;
                end else begin
                    state_nx = ALLOCATE;
                end
            end
            WRITE_BACK: begin
                // The victim address comes from the stored tag. It stays stable because nothing writes during the wait.
                bus.mem_valid = 1'b1;
                bus.mem_rw    = 1'b1;
                bus.mem_addr  = {ent_tag, req_index, 4'b0};
                if (bus.mem_ready) state_nx = ALLOCATE;
            end
            ALLOCATE: begin
                bus.mem_valid = 1'b1;
                if (bus.mem_ready) begin
                    // Install a clean line. COMPARE then hits, and a store is merged on that hit.
                    bus.tag_we     = 1'b1;
                    bus.tag_wdata  = {1'b1, 1'b0, req_tag};
                    bus.data_we    = 1'b1;
                    bus.data_wdata = bus.mem_rdata;
                    state_nx       = COMPARE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register. Reset abandons any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Latch the CPU request. This happens only when IDLE accepts a new request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_rw    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (state == IDLE && bus.cpu_valid) begin
            req_rw    <= bus.cpu_rw;
            req_addr  <= bus.cpu_addr[31:2];
            req_wdata <= bus.cpu_wdata;
        end
    end

    // Completion response. cpu_ready pulses for the cycle after the COMPARE hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cpu_ready <= 1'b0;
            bus.cpu_rdata <= '0;
        end else begin
            bus.cpu_ready <= hit;
            if (hit) bus.cpu_rdata <= req_rw ? 32'h0 : hit_word;
        end
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl.
// It models the tag and data memories and a line memory with a programmable response delay.
module tb_dm_cache_ctrl;
    localparam int TAG_W   = 18;
    localparam int INDEX_W = 10;
    localparam int LINE_W  = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_cache_ctrl_if #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .LINE_W(LINE_W)) bus ();
    dm_cache_ctrl #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .LINE_W(LINE_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Tag and data memories: asynchronous read, write on the rising edge.
    logic [TAG_W+1:0]  tag_mem  [1024] = '{default: '0};
    logic [LINE_W-1:0] data_mem [1024] = '{default: '0};
    assign bus.tag_rdata  = tag_mem[bus.tag_index];
    assign bus.data_rdata = data_mem[bus.data_index];
    always @(posedge clk) begin
        if (bus.tag_we)  tag_mem[bus.tag_index]   <= bus.tag_wdata;
        if (bus.data_we) data_mem[bus.data_index] <= bus.data_wdata;
    end

    function automatic logic [31:0] pat(input logic [31:0] a, input int i);
        logic [1:0] w;
        w = i[1:0];
        return {a[31:4], w, 2'b00} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [127:0] pat_line(input logic [31:0] a);
        return {pat(a, 3), pat(a, 2), pat(a, 1), pat(a, 0)};
    endfunction

    // Line memory responder. It samples just after the rising edge and pulses mem_ready after mem_delay wait cycles.
    logic [127:0] main_mem [logic [31:0]];
    int           mem_delay = 0;
    bit           rsp_en = 1'b1;
    int           inject_req = 0, inject_done = 0;
    int           wr_cnt = 0, rd_cnt = 0, wait_cnt = 0;
    logic [31:0]  last_wr_addr = '0, last_rd_addr = '0;
    logic [127:0] last_wr_line = '0;

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        main_mem[32'h0000_1230] = {32'h3333_0003, 32'h2222_0002, 32'hDEAD_BEEF, 32'h1111_0000};
        forever begin
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            if (inject_req != inject_done) begin
                bus.mem_ready = 1'b1;
                inject_done = inject_req;
            end else if (bus.mem_valid && rsp_en) begin
                if (wait_cnt == mem_delay) begin
                    bus.mem_ready = 1'b1;
                    wait_cnt = 0;
                    if (bus.mem_rw) begin
                        wr_cnt++;
                        last_wr_addr = bus.mem_addr;
                        last_wr_line = bus.mem_wdata;
                        main_mem[bus.mem_addr] = bus.mem_wdata;
                    end else begin
                        rd_cnt++;
                        last_rd_addr = bus.mem_addr;
                        bus.mem_rdata = main_mem.exists(bus.mem_addr) ? main_mem[bus.mem_addr] : pat_line(bus.mem_addr);
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    int n_chk = 0, n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit           rw;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        int           dly;
        logic [31:0]  exp_rdata;
        int           exp_lat;
        int           exp_wr;
        int           exp_rd;
        int           exp_we;
        logic [19:0]  exp_tag;
        logic [31:0]  exp_wr_addr;
        logic [127:0] exp_wr_line;
        logic [31:0]  exp_rd_addr;
    } vec_t;

    function automatic vec_t mkv(input bit rw, input logic [31:0] addr, input logic [31:0] wdata, input int dly,
                                 input logic [31:0] rdata, input int lat, input int wr, input int rd, input int we,
                                 input logic [19:0] tag, input logic [31:0] wa, input logic [127:0] wl, input logic [31:0] ra);
        vec_t v;
        v.rw = rw; v.addr = addr; v.wdata = wdata; v.dly = dly; v.exp_rdata = rdata; v.exp_lat = lat;
        v.exp_wr = wr; v.exp_rd = rd; v.exp_we = we; v.exp_tag = tag;
        v.exp_wr_addr = wa; v.exp_wr_line = wl; v.exp_rd_addr = ra;
        return v;
    endfunction

    // Issue one request. Count cycles until cpu_ready, plus one trailing cycle to check the pulse width.
    task automatic do_req(input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat, output int n_we, output int n_dwe, output int n_rdy);
        bit done;
        done = 1'b0; lat = 0; n_we = 0; n_dwe = 0; n_rdy = 0; rdata = '0;
        @(negedge clk);
        bus.cpu_valid = 1'b1; bus.cpu_rw = rw; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        while (!done && lat < 200) begin
            @(negedge clk);
            bus.cpu_valid = 1'b0;
            lat++;
            if (bus.tag_we)  n_we++;
            if (bus.data_we) n_dwe++;
            if (bus.cpu_ready) begin
                done  = 1'b1;
                rdata = bus.cpu_rdata;
                n_rdy++;
            end
        end
        chk("req_done", done, 1'b1);
        @(negedge clk);
        if (bus.cpu_ready) n_rdy++;
    endtask

    vec_t        vecs [13];
    logic [31:0] rdata;
    int          lat, n_we, n_dwe, n_rdy, wr0, rd0, cnt;
    bit          seen;

    initial begin
        vecs[0]  = mkv(0, 32'h0000_1234, 0, 3, 32'hDEAD_BEEF, 7, 0, 1, 1, 20'h80000, 0, 0, 32'h0000_1230);
        vecs[1]  = mkv(0, 32'h0000_1234, 0, 0, 32'hDEAD_BEEF, 2, 0, 0, 0, 20'h80000, 0, 0, 0);
        vecs[2]  = mkv(1, 32'h0000_1238, 32'hCAFE_F00D, 0, 32'h0, 2, 0, 0, 1, 20'hC0000, 0, 0, 0);
        vecs[3]  = mkv(0, 32'h0000_1238, 0, 0, 32'hCAFE_F00D, 2, 0, 0, 0, 20'hC0000, 0, 0, 0);
        vecs[4]  = mkv(0, 32'h0000_1230, 0, 0, 32'h1111_0000, 2, 0, 0, 0, 20'hC0000, 0, 0, 0);
        vecs[5]  = mkv(0, 32'h0000_123C, 0, 0, 32'h3333_0003, 2, 0, 0, 0, 20'hC0000, 0, 0, 0);
        // 0x0004_1230 -> tag addr[31:14] = 0x10, index 0x123: dirty victim written back first
        vecs[6]  = mkv(0, 32'h0004_1230, 0, 2, pat(32'h0004_1230, 0), 9, 1, 1, 1, 20'h80010, 32'h0000_1230,
                       {32'h3333_0003, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h1111_0000}, 32'h0004_1230);
        // store miss to an invalid line: refill, then merge on the hit
        vecs[7]  = mkv(1, 32'h0000_2004, 32'h1234_5678, 1, 32'h0, 5, 0, 1, 2, 20'hC0000, 0, 0, 32'h0000_2000);
        vecs[8]  = mkv(0, 32'h0000_2004, 0, 0, 32'h1234_5678, 2, 0, 0, 0, 20'hC0000, 0, 0, 0);
        vecs[9]  = mkv(0, 32'h0000_2008, 0, 0, pat(32'h0000_2000, 2), 2, 0, 0, 0, 20'hC0000, 0, 0, 0);
        // 0x0008_2000 -> tag 0x20, index 0x200: zero-wait dirty miss
        vecs[10] = mkv(0, 32'h0008_2000, 0, 0, pat(32'h0008_2000, 0), 5, 1, 1, 1, 20'h80020, 32'h0000_2000,
                       {pat(32'h2000, 3), pat(32'h2000, 2), 32'h1234_5678, pat(32'h2000, 0)}, 32'h0008_2000);
        // store miss to a clean line (tag 0x10 at index 0x123): no write-back
        vecs[11] = mkv(1, 32'h000C_123C, 32'hA5A5_5A5A, 1, 32'h0, 5, 0, 1, 2, 20'hC0030, 0, 0, 32'h000C_1230);
        vecs[12] = mkv(0, 32'h000C_123C, 0, 0, 32'hA5A5_5A5A, 2, 0, 0, 0, 20'hC0030, 0, 0, 0);

        bus.cpu_valid = 1'b0; bus.cpu_rw = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mem_valid", bus.mem_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cpu_ready", bus.cpu_ready, 1'b0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("rst_mem_valid2", bus.mem_valid, 1'b0);
        chk("rst_we", {bus.tag_we, bus.data_we}, 2'b00);
        chk("rst_index", bus.tag_index, 10'h0);

        foreach (vecs[i]) begin
            mem_delay = vecs[i].dly;
            wr0 = wr_cnt; rd0 = rd_cnt;
            do_req(vecs[i].rw, vecs[i].addr, vecs[i].wdata, rdata, lat, n_we, n_dwe, n_rdy);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_ready_pulses", i), n_rdy, 1);
            chk($sformatf("v%0d_mem_writes", i), wr_cnt - wr0, vecs[i].exp_wr);
            chk($sformatf("v%0d_mem_reads", i), rd_cnt - rd0, vecs[i].exp_rd);
            chk($sformatf("v%0d_tag_we", i), n_we, vecs[i].exp_we);
            chk($sformatf("v%0d_data_we", i), n_dwe, vecs[i].exp_we);
            chk($sformatf("v%0d_tag_entry", i), tag_mem[vecs[i].addr[13:4]], vecs[i].exp_tag);
            if (vecs[i].exp_wr != 0) begin
                chk($sformatf("v%0d_wb_addr", i), last_wr_addr, vecs[i].exp_wr_addr);
                chk($sformatf("v%0d_wb_line", i), last_wr_line, vecs[i].exp_wr_line);
            end
            if (vecs[i].exp_rd != 0) chk($sformatf("v%0d_rd_addr", i), last_rd_addr, vecs[i].exp_rd_addr);
        end

        // Reset in the middle of a write-back. The line at 0x123 is dirty, and memory never answers.
        rsp_en = 1'b0;
        @(negedge clk);
        bus.cpu_valid = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = 32'h0010_1230;
        @(negedge clk);
        bus.cpu_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (bus.mem_valid && bus.mem_rw) seen = 1'b1;
            else @(negedge clk);
        end
        chk("wb_reached", seen, 1'b1);
        chk("wb_addr_live", bus.mem_addr, 32'h000C_1230);
        #2 rst = 1'b1;
        #1;
        chk("async_mem_valid", bus.mem_valid, 1'b0);
        chk("async_cpu_ready", bus.cpu_ready, 1'b0);
        chk("async_index_idle", bus.tag_index, 10'h0);
        @(negedge clk);
        rst = 1'b0;
        rsp_en = 1'b1;
        inject_req++;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_valid || bus.tag_we || bus.data_we || bus.cpu_ready) cnt++;
        end
        chk("stray_ready_ignored", cnt, 0);
        chk("tag_after_abort", tag_mem[10'h123], 20'hC0030);

        mem_delay = 0;
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_req(1'b0, 32'h000C_123C, 32'h0, rdata, lat, n_we, n_dwe, n_rdy);
        chk("recover_rdata", rdata, 32'hA5A5_5A5A);
        chk("recover_latency", lat, 2);
        chk("recover_no_mem", (wr_cnt - wr0) + (rd_cnt - rd0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
